// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants: field parameters, parameter-set encoding,
// per-set matrix dimensions and the ExpandA controller state encoding.
package dilithium_pkg;

    localparam int Q         = 8380417;
    localparam int N         = 256;
    localparam int SEED_SIZE = 272;

    typedef enum logic [1:0] {
        MODE_44  = 2'd0,
        MODE_65  = 2'd1,
        MODE_87  = 2'd2,
        MODE_BAD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_ADVANCE,
        ST_FLUSH
    } ctrl_state_e;

    // Row count K of matrix A for a parameter set (0 for the illegal code).
    function automatic logic [3:0] mode_k(input mode_e m);
        case (m)
            MODE_44: mode_k = 4'd4;
            MODE_65: mode_k = 4'd6;
            MODE_87: mode_k = 4'd8;
            default: mode_k = 4'd0;
        endcase
    endfunction

    // Column count L of matrix A for a parameter set (0 for the illegal code).
    function automatic logic [3:0] mode_l(input mode_e m);
        case (m)
            MODE_44: mode_l = 4'd4;
            MODE_65: mode_l = 4'd5;
            MODE_87: mode_l = 4'd7;
            default: mode_l = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/expand_a_ctrl_if.sv
// Link between the ExpandA sequencer (master) and the shared rejection sampler (slave).
interface expand_a_ctrl_if #(
    parameter int SEED_SIZE = dilithium_pkg::SEED_SIZE
) ();

    logic                 samp_start;
    logic                 samp_rst;
    logic [SEED_SIZE-1:0] samp_seed;
    logic [3:0]           samp_k;
    logic [3:0]           samp_l;
    logic                 samp_done;

    modport master (
        output samp_start, samp_rst, samp_seed, samp_k, samp_l,
        input  samp_done
    );

    modport slave (
        input  samp_start, samp_rst, samp_seed, samp_k, samp_l,
        output samp_done
    );

endinterface

// File: rtl/matrix_index_ctr.sv
// Row-major (k, l) walker over a K x L matrix with last-entry detection.
module matrix_index_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] k_size,
    input  logic [3:0] l_size,
    input  logic       clr,
    input  logic       step,
    output logic [3:0] k,
    output logic [3:0] l,
    output logic       last
);

    logic l_wrap;

    assign l_wrap = (l == l_size - 4'd1);
    assign last   = l_wrap && (k == k_size - 4'd1);

    // Column advances fastest; wrapping the column bumps the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
            l <= '0;
        end else if (clr) begin
            k <= '0;
            l <= '0;
        end else if (step) begin
            if (l_wrap) begin
                l <= '0;
                k <= k + 4'd1;
            end else begin
                l <= l + 4'd1;
            end
        end
    end

endmodule

// File: rtl/expand_a_ctrl.sv
// ExpandA sequencer: launches the shared rejection sampler once per matrix
// entry (k, l) with seed rho || l || k, with watchdog and abort handling.
module expand_a_ctrl #(
    parameter int K_MAX          = 8,
    parameter int L_MAX          = 7,
    parameter int SEED_SIZE      = 272,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [255:0]  rho,
    output logic          busy,
    output logic          done,
    output logic          error,
    expand_a_ctrl_if.master sampler
);

    import dilithium_pkg::*;

    localparam logic [TIMEOUT_W-1:0] TIMER_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_e          state;
    logic [255:0]         rho_q;
    logic [3:0]           k_size_q;
    logic [3:0]           l_size_q;
    logic [3:0]           idx_k;
    logic [3:0]           idx_l;
    logic                 idx_last;
    logic                 idx_clr;
    logic                 idx_step;
    logic [TIMEOUT_W-1:0] timer;
    logic                 flush_cnt;
    logic                 samp_start_q;
    logic                 samp_rst_q;
    logic [3:0]           req_k;
    logic [3:0]           req_l;
    logic                 mode_ok;
    logic [SEED_SIZE-1:0] seed;

    // Decode the requested parameter set; sets larger than this build supports are illegal.
    always_comb begin
        req_k    = mode_k(mode_e'(mode));
        req_l    = mode_l(mode_e'(mode));
        mode_ok  = (mode_e'(mode) != MODE_BAD)
                && (int'(req_k) <= K_MAX) && (int'(req_l) <= L_MAX);
        idx_clr  = (state == ST_IDLE) && start && mode_ok;
        idx_step = (state == ST_ADVANCE) && !abort && !idx_last;
    end

    matrix_index_ctr u_index (
        .clk    (clk),
        .rst_n  (rst_n),
        .k_size (k_size_q),
        .l_size (l_size_q),
        .clr    (idx_clr),
        .step   (idx_step),
        .k      (idx_k),
        .l      (idx_l),
        .last   (idx_last)
    );

    // Column byte precedes row byte: A[r][s] is sampled from rho || s || r.
    assign seed               = SEED_SIZE'({4'b0, idx_k, 4'b0, idx_l, rho_q});
    assign sampler.samp_seed  = seed;
    assign sampler.samp_k     = idx_k;
    assign sampler.samp_l     = idx_l;
    assign sampler.samp_start = samp_start_q;
    assign sampler.samp_rst   = samp_rst_q;

    // Main sequencer; done is raised on the accepted completion of the last
    // entry so it lands in the ADVANCE cycle, which then only returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rho_q        <= '0;
            k_size_q     <= '0;
            l_size_q     <= '0;
            timer        <= '0;
            flush_cnt    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            samp_start_q <= 1'b0;
            samp_rst_q   <= 1'b0;
        end else begin
            done         <= 1'b0;
            error        <= 1'b0;
            samp_start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode_ok) begin
                            rho_q        <= rho;
                            k_size_q     <= req_k;
                            l_size_q     <= req_l;
                            busy         <= 1'b1;
                            samp_start_q <= 1'b1;
                            state        <= ST_LAUNCH;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    timer <= '0;
                    if (abort) begin
                        state      <= ST_FLUSH;
                        samp_rst_q <= 1'b1;
                        flush_cnt  <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state      <= ST_FLUSH;
                        samp_rst_q <= 1'b1;
                        flush_cnt  <= 1'b0;
                    end else if (sampler.samp_done) begin
                        state <= ST_ADVANCE;
                        if (idx_last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end else if (timer == TIMER_LIMIT) begin
                        state      <= ST_FLUSH;
                        samp_rst_q <= 1'b1;
                        flush_cnt  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    if (idx_last) begin
                        state <= ST_IDLE;
                    end else if (abort) begin
                        state      <= ST_FLUSH;
                        samp_rst_q <= 1'b1;
                        flush_cnt  <= 1'b0;
                    end else begin
                        samp_start_q <= 1'b1;
                        state        <= ST_LAUNCH;
                    end
                end
                ST_FLUSH: begin
                    if (!flush_cnt) begin
                        flush_cnt <= 1'b1;
                    end else begin
                        samp_rst_q <= 1'b0;
                        error      <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
